// File: rtl/enc_readout_pkg.sv
// Shared opcodes, FSM state encoding and STATUS word layout for the encoder
// readout sequencer.
package enc_readout_pkg;

  localparam logic [1:0] OP_SNAP   = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CLR_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int STAT_OVR_BIT     = 0;
  localparam int STAT_IDX_ERR_BIT = 1;
  localparam int STAT_NUM_LSB     = 16;
  localparam int STAT_SEQ_LSB     = 24;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_0000;

  function automatic logic [31:0] status_word(input logic [7:0] seq,
                                              input logic [7:0] num,
                                              input logic       idx_err,
                                              input logic       ovr);
    logic [31:0] w;
    w = '0;
    w[STAT_SEQ_LSB +: 8]  = seq;
    w[STAT_NUM_LSB +: 8]  = num;
    w[STAT_IDX_ERR_BIT]   = idx_err;
    w[STAT_OVR_BIT]       = ovr;
    return w;
  endfunction

endpackage

// File: rtl/enc_readout_ctrl_shadow_bank.sv
// Shadow register bank: all entries captured together on snap_en_i, one entry
// read back combinationally by index (out-of-range index reads zero).
module enc_shadow_bank
  import enc_readout_pkg::*;
#(
  parameter int NUM_ENC = 4,
  parameter int CNT_W   = 32,
  parameter int IDX_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     snap_en_i,
  input  logic [NUM_ENC*CNT_W-1:0] enc_count_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [31:0]              rd_data_o
);

  logic [31:0] snap_val [NUM_ENC];
  logic [31:0] shadow_q [NUM_ENC];

  for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_fit
    if (CNT_W >= 32) begin : g_trunc
      assign snap_val[gi] = enc_count_i[gi*CNT_W +: 32];
    end else begin : g_zext
      assign snap_val[gi] = {{(32-CNT_W){1'b0}}, enc_count_i[gi*CNT_W +: CNT_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENC; i++) shadow_q[i] <= '0;
    end else if (snap_en_i) begin
      for (int i = 0; i < NUM_ENC; i++) shadow_q[i] <= snap_val[i];
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_data_o = shadow_q[i];
    end
  end

endmodule

// File: rtl/enc_readout_ctrl.sv
// Toggle-handshake command sequencer sharing one 32-bit PIO readout word
// among NUM_ENC encoder counters (SNAP / READ / CLEAR / STATUS).
//
// state    | meaning
// IDLE     | waiting for cmd_tgl != ack_tgl; samples cmd_op/cmd_idx
// DECODE   | range-checks the index for READ/CLEAR
// EXEC     | performs the command, updates rd_data / starts clear pulse
// CLR_WAIT | holds enc_clr[idx] high until CLR_PULSE cycles have elapsed
// DONE     | returns ack_tgl to the latched toggle value
module enc_readout_ctrl
  import enc_readout_pkg::*;
#(
  parameter int NUM_ENC   = 4,
  parameter int CNT_W     = 32,
  parameter int IDX_W     = 4,
  parameter int CLR_PULSE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_ENC*CNT_W-1:0] enc_count,
  input  logic                     cmd_tgl,
  input  logic [1:0]               cmd_op,
  input  logic [IDX_W-1:0]         cmd_idx,
  output logic [31:0]              rd_data,
  output logic                     ack_tgl,
  output logic                     busy,
  output logic [NUM_ENC-1:0]       enc_clr,
  output logic [7:0]               snap_seq
);

  localparam int          PW        = $clog2(CLR_PULSE + 1);
  localparam logic [31:0] NUM_ENC_W = 32'(NUM_ENC);
  localparam logic [7:0]  NUM_ENC_B = 8'(NUM_ENC);

  state_e             state_q;
  logic [1:0]         op_q;
  logic [IDX_W-1:0]   idx_q;
  logic               tgl_q;
  logic               tgl_prev_q;
  logic               idx_bad_q;
  logic               idx_err_q;
  logic               ovr_q;
  logic [PW-1:0]      pulse_q;
  logic [31:0]        rd_data_q;
  logic               ack_q;
  logic               busy_q;
  logic [NUM_ENC-1:0] enc_clr_q;
  logic [7:0]         snap_seq_q;

  logic [7:0]  snap_seq_d;
  logic        ovr_evt;
  logic        snap_en;
  logic [31:0] shadow_rd;

  assign snap_seq_d = snap_seq_q + 8'd1;
  assign ovr_evt    = (state_q != ST_IDLE) && (cmd_tgl != tgl_prev_q);
  assign snap_en    = (state_q == ST_EXEC) && (op_q == OP_SNAP);

  enc_shadow_bank #(
    .NUM_ENC (NUM_ENC),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .snap_en_i   (snap_en),
    .enc_count_i (enc_count),
    .rd_idx_i    (idx_q),
    .rd_data_o   (shadow_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_SNAP;
      idx_q      <= '0;
      tgl_q      <= 1'b0;
      tgl_prev_q <= 1'b0;
      idx_bad_q  <= 1'b0;
      idx_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
      pulse_q    <= '0;
      rd_data_q  <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      enc_clr_q  <= '0;
      snap_seq_q <= '0;
    end else begin
      tgl_prev_q <= cmd_tgl;
      if (ovr_evt) ovr_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (cmd_tgl != ack_q) begin
            op_q    <= cmd_op;
            idx_q   <= cmd_idx;
            tgl_q   <= cmd_tgl;
            busy_q  <= 1'b1;
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          idx_bad_q <= ((op_q == OP_READ) || (op_q == OP_CLEAR)) &&
                       (32'(idx_q) >= NUM_ENC_W);
          state_q   <= ST_EXEC;
        end

        ST_EXEC: begin
          state_q <= ST_DONE;
          case (op_q)
            OP_SNAP: begin
              snap_seq_q <= snap_seq_d;
              rd_data_q  <= {snap_seq_d, 24'h0};
            end
            OP_READ: begin
              if (idx_bad_q) begin
                rd_data_q <= ERR_PATTERN | 32'(idx_q);
                idx_err_q <= 1'b1;
              end else begin
                rd_data_q <= shadow_rd;
              end
            end
            OP_CLEAR: begin
              if (idx_bad_q) begin
                idx_err_q <= 1'b1;
              end else begin
                for (int i = 0; i < NUM_ENC; i++) enc_clr_q[i] <= (idx_q == IDX_W'(i));
                pulse_q <= PW'(CLR_PULSE);
                state_q <= ST_CLR_WAIT;
              end
            end
            default: begin
              // A toggle arriving on this very edge is still recorded.
              rd_data_q <= status_word(snap_seq_q, NUM_ENC_B, idx_err_q, ovr_q);
              idx_err_q <= 1'b0;
              ovr_q     <= ovr_evt;
            end
          endcase
        end

        ST_CLR_WAIT: begin
          if (pulse_q == PW'(1)) begin
            enc_clr_q <= '0;
            rd_data_q <= '0;
            state_q   <= ST_DONE;
          end else begin
            pulse_q <= pulse_q - PW'(1);
          end
        end

        ST_DONE: begin
          ack_q   <= tgl_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign ack_tgl  = ack_q;
  assign busy     = busy_q;
  assign enc_clr  = enc_clr_q;
  assign snap_seq = snap_seq_q;

endmodule

// File: tb/tb_enc_readout_ctrl.sv
// Self-checking bench for enc_readout_ctrl: directed vector table, hand-written
// corner sequences, and randomized commands against a behavioural model.
module tb_enc_readout_ctrl;

  localparam int NUM_ENC   = 4;
  localparam int CNT_W     = 32;
  localparam int IDX_W     = 4;
  localparam int CLR_PULSE = 4;

  localparam logic [1:0] C_SNAP   = 2'd0;
  localparam logic [1:0] C_READ   = 2'd1;
  localparam logic [1:0] C_CLEAR  = 2'd2;
  localparam logic [1:0] C_STATUS = 2'd3;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_ENC*CNT_W-1:0] enc_count;
  logic                     cmd_tgl;
  logic [1:0]               cmd_op;
  logic [IDX_W-1:0]         cmd_idx;
  logic [31:0]              rd_data;
  logic                     ack_tgl;
  logic                     busy;
  logic [NUM_ENC-1:0]       enc_clr;
  logic [7:0]               snap_seq;

  int vectors;
  int miscompares;

  logic [31:0] m_live   [NUM_ENC];
  logic [31:0] m_shadow [NUM_ENC];
  logic [7:0]  m_seq;
  logic        m_err;
  logic        m_ovr;
  logic [31:0] m_rd;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [31:0] c3, c2, c1, c0;
    logic [31:0] exp_rd;
    logic [7:0]  exp_seq;
  } vec_t;

  vec_t tbl [14];

  enc_readout_ctrl #(
    .NUM_ENC   (NUM_ENC),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W),
    .CLR_PULSE (CLR_PULSE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_count (enc_count),
    .cmd_tgl   (cmd_tgl),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .rd_data   (rd_data),
    .ack_tgl   (ack_tgl),
    .busy      (busy),
    .enc_clr   (enc_clr),
    .snap_seq  (snap_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_live();
    enc_count = {m_live[3], m_live[2], m_live[1], m_live[0]};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ENC; i++) m_shadow[i] = '0;
    m_seq = '0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_step(input logic [1:0] op, input logic [3:0] idx,
                            output logic [31:0] exp_rd);
    int iv;
    iv = int'(idx);
    case (op)
      C_SNAP: begin
        for (int i = 0; i < NUM_ENC; i++) m_shadow[i] = m_live[i];
        m_seq = m_seq + 8'd1;
        m_rd  = {m_seq, 24'h0};
      end
      C_READ: begin
        if (iv < NUM_ENC) m_rd = m_shadow[iv];
        else begin
          m_rd  = 32'hDEAD_0000 + 32'(idx);
          m_err = 1'b1;
        end
      end
      C_CLEAR: begin
        if (iv < NUM_ENC) m_rd = 32'h0;
        else m_err = 1'b1;
      end
      default: begin
        m_rd  = (32'(m_seq) << 24) + (32'(NUM_ENC) << 16) + (32'(m_err) << 1) + 32'(m_ovr);
        m_err = 1'b0;
        m_ovr = 1'b0;
      end
    endcase
    exp_rd = m_rd;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] idx,
                         input logic [31:0] exp_rd, input logic [7:0] exp_seq,
                         input string name);
    logic [3:0] exp_clr;
    int exp_lat, lat, hits, bad;
    bit got;
    exp_clr = '0;
    if (op == C_CLEAR && int'(idx) < NUM_ENC) exp_clr[idx[1:0]] = 1'b1;
    exp_lat = (exp_clr != 0) ? 3 + CLR_PULSE : 3;
    @(posedge clk); #1;
    cmd_op  = op;
    cmd_idx = idx;
    cmd_tgl = ~cmd_tgl;
    got = 0; lat = -1; hits = 0; bad = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (exp_clr != 0 && enc_clr == exp_clr) hits++;
      else if (enc_clr != 0) bad++;
      if (k == 1) check(busy === 1'b1, {name, " busy_early"}, 32'(busy), 32'd1);
      if (ack_tgl === cmd_tgl) begin
        got = 1;
        lat = k - 1;
      end
    end
    check(got && lat == exp_lat, {name, " ack_latency"}, 32'(lat), 32'(exp_lat));
    check(rd_data === exp_rd, {name, " rd_data"}, rd_data, exp_rd);
    check(snap_seq === exp_seq, {name, " snap_seq"}, 32'(snap_seq), 32'(exp_seq));
    check(busy === 1'b0, {name, " busy_at_ack"}, 32'(busy), 32'd0);
    check(hits == ((exp_clr != 0) ? CLR_PULSE : 0) && bad == 0,
          {name, " enc_clr_pulse"}, 32'(hits * 256 + bad),
          32'(((exp_clr != 0) ? CLR_PULSE : 0) * 256));
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [3:0] idx, input string name);
    logic [31:0] e;
    model_step(op, idx, e);
    run_cmd(op, idx, e, m_seq, name);
  endtask

  initial begin
    logic [31:0] e;
    logic        t1;
    bit          got;
    vectors = 0;
    miscompares = 0;

    //            op        idx    c3            c2     c1             c0     exp_rd         seq
    tbl[0]  = '{C_STATUS, 4'd0,  32'd4,        32'd3, 32'd2,         32'd1, 32'h0004_0000, 8'd0};
    tbl[1]  = '{C_READ,   4'd0,  32'd4,        32'd3, 32'd2,         32'd1, 32'h0000_0000, 8'd0};
    tbl[2]  = '{C_SNAP,   4'd0,  32'd4,        32'd3, 32'h0000_1234, 32'd1, 32'h0100_0000, 8'd1};
    tbl[3]  = '{C_READ,   4'd1,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0000_1234, 8'd1};
    tbl[4]  = '{C_READ,   4'd3,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0000_0004, 8'd1};
    tbl[5]  = '{C_READ,   4'd5,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'hDEAD_0005, 8'd1};
    tbl[6]  = '{C_STATUS, 4'd0,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0104_0002, 8'd1};
    tbl[7]  = '{C_STATUS, 4'd0,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0104_0000, 8'd1};
    tbl[8]  = '{C_CLEAR,  4'd2,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0000_0000, 8'd1};
    tbl[9]  = '{C_READ,   4'd0,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0000_0001, 8'd1};
    tbl[10] = '{C_CLEAR,  4'd15, 32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0000_0001, 8'd1};
    tbl[11] = '{C_STATUS, 4'd0,  32'd4,        32'd3, 32'h0000_9999, 32'd1, 32'h0104_0002, 8'd1};
    tbl[12] = '{C_SNAP,   4'd0,  32'hAAAA_5555, 32'd7, 32'd8,        32'd9, 32'h0200_0000, 8'd2};
    tbl[13] = '{C_READ,   4'd3,  32'hAAAA_5555, 32'd7, 32'd8,        32'd9, 32'hAAAA_5555, 8'd2};

    rst_n = 1'b0; cmd_tgl = 1'b0; cmd_op = '0; cmd_idx = '0;
    enc_count = {32'd4, 32'd3, 32'd2, 32'd1};
    #12;
    check(rd_data === 32'h0, "reset rd_data", rd_data, 32'h0);
    check(ack_tgl === 1'b0, "reset ack_tgl", 32'(ack_tgl), 32'h0);
    check(busy === 1'b0, "reset busy", 32'(busy), 32'h0);
    check(enc_clr === '0, "reset enc_clr", 32'(enc_clr), 32'h0);
    check(snap_seq === 8'h0, "reset snap_seq", 32'(snap_seq), 32'h0);
    #11 rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      enc_count = {tbl[r].c3, tbl[r].c2, tbl[r].c1, tbl[r].c0};
      run_cmd(tbl[r].op, tbl[r].idx, tbl[r].exp_rd, tbl[r].exp_seq, $sformatf("tbl%0d", r));
    end

    // Reset in the middle of a clear pulse.
    @(posedge clk); #1;
    cmd_op = C_CLEAR; cmd_idx = 4'd2; cmd_tgl = ~cmd_tgl;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    check(enc_clr === 4'b0100, "midclr enc_clr_high", 32'(enc_clr), 32'h4);
    #2 rst_n = 1'b0; cmd_tgl = 1'b0;
    #1;
    check(enc_clr === '0, "midclr enc_clr_async", 32'(enc_clr), 32'h0);
    check(ack_tgl === 1'b0, "midclr ack_tgl", 32'(ack_tgl), 32'h0);
    check(busy === 1'b0, "midclr busy", 32'(busy), 32'h0);
    check(rd_data === 32'h0, "midclr rd_data", rd_data, 32'h0);
    check(snap_seq === 8'h0, "midclr snap_seq", 32'(snap_seq), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    model_reset();
    for (int i = 0; i < NUM_ENC; i++) m_live[i] = 32'h1111_0000 + 32'(i);
    apply_live();
    model_cmd(C_READ, 4'd3, "shadow_cleared");

    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < NUM_ENC; i++) m_live[i] = $urandom;
      apply_live();
      model_cmd(C_SNAP, 4'd0, "snap_wrap");
    end
    check(snap_seq === 8'h00, "snap_seq_wrapped", 32'(snap_seq), 32'h0);
    model_cmd(C_READ, 4'd2, "read_after_wrap");

    // Two extra toggles while a CLEAR is in flight: second command is lost.
    @(posedge clk); #1;
    cmd_op = C_CLEAR; cmd_idx = 4'd1; cmd_tgl = ~cmd_tgl; t1 = cmd_tgl;
    model_step(C_CLEAR, 4'd1, e);
    @(posedge clk); #1;
    @(posedge clk); #1; cmd_tgl = ~cmd_tgl;
    @(posedge clk); #1; cmd_tgl = ~cmd_tgl;
    m_ovr = 1'b1;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk); #1;
      if (ack_tgl === t1) got = 1;
    end
    check(got, "ovr ack_seen", 32'(ack_tgl), 32'(t1));
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    check(ack_tgl === cmd_tgl, "ovr ack_final", 32'(ack_tgl), 32'(cmd_tgl));
    check(busy === 1'b0, "ovr no_reexec", 32'(busy), 32'h0);
    check(rd_data === e, "ovr rd_data", rd_data, e);
    model_cmd(C_STATUS, 4'd0, "ovr_status");
    model_cmd(C_STATUS, 4'd0, "ovr_status_cleared");

    for (int n = 0; n < 200; n++) begin
      logic [1:0] op;
      logic [3:0] idx;
      for (int i = 0; i < NUM_ENC; i++)
        if ($urandom_range(0, 3) == 0) m_live[i] = $urandom;
      apply_live();
      op  = 2'($urandom_range(0, 3));
      idx = 4'($urandom_range(0, 7));
      model_cmd(op, idx, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
